// File: rtl/id1000500b_conv_sequencer_if.sv
// Handshake and memory-address bundle between the AIP host side and the
// convolution sequencer.
interface id1000500b_conv_sequencer_if #(
  parameter int ADDR_Y = 5,
  parameter int ADDR_Z = 6
);
  logic              start;
  logic [ADDR_Y-1:0] sizeY;
  logic [ADDR_Y-1:0] memY_addr;
  logic [2:0]        memX_addr;
  logic              acc_clr;
  logic              mac_en;
  logic [ADDR_Z-1:0] memZ_addr;
  logic              writeZ;
  logic              busy;
  logic              done;

  modport master (
    output start, sizeY,
    input  memY_addr, memX_addr, acc_clr, mac_en, memZ_addr, writeZ, busy, done
  );

  modport slave (
    input  start, sizeY,
    output memY_addr, memX_addr, acc_clr, mac_en, memZ_addr, writeZ, busy, done
  );
endinterface

// File: rtl/id1000500b_conv_sequencer.sv
// Control sequencer for a 1-D convolution z = x * y: walks n over the full
// output length and k over the kernel, steering memory reads and the MAC.
module id1000500b_conv_sequencer #(
  parameter int SIZE_X = 5,
  parameter int ADDR_Y = 5,
  parameter int ADDR_Z = 6
) (
  input logic clk,
  input logic rst_a,
  id1000500b_conv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, FLUSH, WRITE, DONE} state_t;

  // Compare width wide enough for both n and sizeY plus a borrow bit.
  localparam int CW = ((ADDR_Y > ADDR_Z) ? ADDR_Y : ADDR_Z) + 1;
  localparam logic [2:0] K_LAST = 3'(SIZE_X - 1);

  state_t            state_reg, state_next;
  logic [ADDR_Z-1:0] n_reg, n_next;
  logic [ADDR_Z-1:0] last_reg, last_next;
  logic [2:0]        k_reg, k_next;
  logic [ADDR_Y-1:0] size_reg, size_next;
  logic [ADDR_Y-1:0] y_hold_reg;
  logic              mac_en_reg;

  logic [CW-1:0]     diff_w;
  logic              term_valid;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_reg  <= IDLE;
      n_reg      <= '0;
      last_reg   <= '0;
      k_reg      <= '0;
      size_reg   <= '0;
      y_hold_reg <= '0;
      mac_en_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      n_reg      <= n_next;
      last_reg   <= last_next;
      k_reg      <= k_next;
      size_reg   <= size_next;
      y_hold_reg <= bus.memY_addr;
      // Read data arrives one cycle after the address, so the MAC enable lags.
      mac_en_reg <= term_valid;
    end
  end

  always_comb begin
    diff_w     = CW'(n_reg) - CW'(k_reg);
    term_valid = (state_reg == SCAN) && (CW'(n_reg) >= CW'(k_reg)) &&
                 (diff_w < CW'(size_reg));
    // Invalid terms leave the memY address parked on its last valid value.
    bus.memY_addr = term_valid ? diff_w[ADDR_Y-1:0] : y_hold_reg;
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    last_next  = last_reg;
    k_next     = k_reg;
    size_next  = size_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.sizeY != '0) begin
            size_next  = bus.sizeY;
            last_next  = ADDR_Z'(bus.sizeY) + ADDR_Z'(SIZE_X - 2);
            n_next     = '0;
            state_next = CLEAR;
          end else begin
            state_next = DONE;
          end
        end
      end
      CLEAR: begin
        k_next     = '0;
        state_next = SCAN;
      end
      SCAN: begin
        if (k_reg == K_LAST) begin
          k_next     = '0;
          state_next = FLUSH;
        end else begin
          k_next = k_reg + 3'd1;
        end
      end
      FLUSH: state_next = WRITE;
      WRITE: begin
        if (n_reg == last_reg) begin
          state_next = DONE;
        end else begin
          n_next     = n_reg + 1'b1;
          state_next = CLEAR;
        end
      end
      DONE: begin
        n_next     = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.acc_clr   = (state_reg == CLEAR);
    bus.mac_en    = mac_en_reg;
    bus.memX_addr = (state_reg == SCAN) ? k_reg : 3'd0;
    bus.writeZ    = (state_reg == WRITE);
    bus.memZ_addr = (state_reg == WRITE) ? n_reg : '0;
    bus.busy      = (state_reg == CLEAR) || (state_reg == SCAN) ||
                    (state_reg == FLUSH) || (state_reg == WRITE);
    bus.done      = (state_reg == DONE);
  end

endmodule

// File: tb/tb_id1000500b_conv_sequencer.sv
// Directed bench: behavioural memories and accumulator around the sequencer,
// with a queue of expected memZ writes compared as writes appear.
module tb_id1000500b_conv_sequencer;
  localparam int SX = 5;
  localparam int AY = 5;
  localparam int AZ = 6;

  logic clk = 1'b0;
  logic rst_a;

  id1000500b_conv_sequencer_if #(.ADDR_Y(AY), .ADDR_Z(AZ)) bus ();

  id1000500b_conv_sequencer #(.SIZE_X(SX), .ADDR_Y(AY), .ADDR_Z(AZ)) u_dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem_x [8];
  logic [7:0]  mem_y [32];
  logic [31:0] acc;
  logic [2:0]  px;
  logic [4:0]  py;

  int writes = 0, busy_cnt = 0, done_cnt = 0, mac_run = 0, jw = 0;
  int cyc = 0, last_wr_cyc = 0, done_cyc = 0, cap_n = -1;
  int          exp_addr_q[$];
  logic [31:0] exp_val_q[$];
  int          exp_mac_q[$];
  int          y_seq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected z[n] and number of valid terms per n, straight from the sum definition.
  task automatic push_expect(input int sy);
    int len;
    len = (sy == 0) ? 0 : sy + SX - 1;
    for (int n = 0; n < len; n++) begin
      logic [31:0] v;
      int mc;
      v  = 0;
      mc = 0;
      for (int k = 0; k < SX; k++) begin
        if (n - k >= 0 && n - k < sy) begin
          v  = v + 32'(mem_x[k]) * 32'(mem_y[n-k]);
          mc++;
        end
      end
      exp_addr_q.push_back(n);
      exp_val_q.push_back(v);
      exp_mac_q.push_back(mc);
    end
  endtask

  task automatic monitor();
    cyc++;
    if (rst_a) begin
      acc = 0; px = 0; py = 0; mac_run = 0;
      return;
    end
    if (bus.acc_clr) acc = 0;
    else if (bus.mac_en) begin
      acc = acc + 32'(mem_x[px]) * 32'(mem_y[py]);
      mac_run++;
      if (jw == cap_n) y_seq.push_back(int'(py));
    end
    check("exclusive_strobes",
          32'(int'(bus.acc_clr) + int'(bus.writeZ) + int'(bus.done) > 1), 32'd0);
    if (bus.busy) busy_cnt++;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.writeZ) begin
      writes++;
      last_wr_cyc = cyc;
      $display("write addr=%0d val=%0d macs=%0d", bus.memZ_addr, acc, mac_run);
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        check("memZ_addr", 32'(bus.memZ_addr), 32'(exp_addr_q.pop_front()));
        check("z_value", acc, exp_val_q.pop_front());
        check("mac_count", 32'(mac_run), 32'(exp_mac_q.pop_front()));
      end
      mac_run = 0;
      jw++;
    end
    px = bus.memX_addr;
    py = bus.memY_addr;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int sy);
    bus.sizeY = AY'(sy);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int c;
    c = 0;
    while (done_cnt == d0 && c < 600) begin
      tick();
      c++;
    end
    if (c >= 600) check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic job(input int sy, input bit repulse);
    int w0, b0, d0, len;
    len = (sy == 0) ? 0 : sy + SX - 1;
    w0 = writes; b0 = busy_cnt; d0 = done_cnt; jw = 0;
    push_expect(sy);
    start_job(sy);
    if (repulse) begin
      repeat (10) tick();
      bus.sizeY = AY'(7);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    wait_done(d0);
    repeat (20) tick();
    check($sformatf("writes_sy%0d", sy), 32'(writes - w0), 32'(len));
    check($sformatf("busy_cycles_sy%0d", sy), 32'(busy_cnt - b0), 32'(len * (SX + 3)));
    check($sformatf("done_count_sy%0d", sy), 32'(done_cnt - d0), 32'd1);
    check("queue_drained", 32'(exp_addr_q.size()), 32'd0);
    if (len > 0) check("done_after_last_write", 32'(done_cyc - last_wr_cyc), 32'd1);
  endtask

  initial begin
    int w0, d0;
    for (int i = 0; i < 8; i++)  mem_x[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 32; i++) mem_y[i] = 8'($urandom_range(1, 255));
    acc = 0; px = 0; py = 0;
    rst_a = 1'b1;
    bus.start = 1'b0;
    bus.sizeY = '0;
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_writeZ", 32'(bus.writeZ), 32'd0);
    check("rst_acc_clr", 32'(bus.acc_clr), 32'd0);
    check("rst_mac_en", 32'(bus.mac_en), 32'd0);
    check("rst_addrs", 32'({bus.memY_addr, bus.memX_addr, bus.memZ_addr}), 32'd0);
    rst_a = 1'b0;
    repeat (2) tick();

    job(1, 1'b0);

    cap_n = 2;
    y_seq.delete();
    job(3, 1'b0);
    cap_n = -1;
    check("yseq_len", 32'(y_seq.size()), 32'd3);
    if (y_seq.size() == 3) begin
      check("yseq0", 32'(y_seq[0]), 32'd2);
      check("yseq1", 32'(y_seq[1]), 32'd1);
      check("yseq2", 32'(y_seq[2]), 32'd0);
    end

    // Empty input: straight IDLE -> DONE with no datapath activity.
    w0 = writes; d0 = done_cnt;
    start_job(0);
    check("sy0_done_now", 32'(bus.done), 32'd1);
    check("sy0_busy", 32'(bus.busy), 32'd0);
    check("sy0_acc_clr", 32'(bus.acc_clr), 32'd0);
    tick();
    check("sy0_done_gone", 32'(bus.done), 32'd0);
    repeat (5) tick();
    check("sy0_done_count", 32'(done_cnt - d0), 32'd1);
    check("sy0_writes", 32'(writes - w0), 32'd0);

    job(3, 1'b1);

    // Abort mid-job during SCAN of n=2.
    w0 = writes; d0 = done_cnt; jw = 0;
    push_expect(31);
    start_job(31);
    begin
      int c;
      c = 0;
      while (writes - w0 < 2 && c < 100) begin
        tick();
        c++;
      end
      if (c >= 100) check("abort_wait_timeout", 32'd1, 32'd0);
    end
    tick();
    tick();
    check("pre_abort_busy", 32'(bus.busy), 32'd1);
    check("pre_abort_k", 32'(bus.memX_addr), 32'd1);
    #2 rst_a = 1'b1;
    #1;
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_mac_en", 32'(bus.mac_en), 32'd0);
    check("async_addrs", 32'({bus.memY_addr, bus.memX_addr, bus.memZ_addr}), 32'd0);
    check("async_strobes", 32'({bus.acc_clr, bus.writeZ, bus.done}), 32'd0);
    exp_addr_q.delete();
    exp_val_q.delete();
    exp_mac_q.delete();
    repeat (2) tick();
    rst_a = 1'b0;
    repeat (5) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    job(2, 1'b0);
    job(31, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
